// File: rtl/async_fifo_read_drain_pkg.sv
// Shared definitions for the async FIFO read-side drain logic:
// FSM state encodings, skid buffer depth and the pointer helper.
package async_fifo_read_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  localparam int SKID_DEPTH = 3;

  typedef logic [1:0] skid_ptr_t;

  // Advance a skid buffer pointer, wrapping modulo SKID_DEPTH.
  function automatic skid_ptr_t skid_ptr_inc(input skid_ptr_t ptr);
    return (ptr == skid_ptr_t'(SKID_DEPTH - 1)) ? skid_ptr_t'(0) : ptr + skid_ptr_t'(1);
  endfunction

endpackage

// File: rtl/async_fifo_read_drain_skid_buf.sv
// Three-entry skid buffer that absorbs the FIFO read latency.
// push writes at wr_ptr, pop retires the head at rd_ptr, count reports occupancy.
module fifo_rd_skid_buf
  import async_fifo_read_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] entry_q [SKID_DEPTH];
  skid_ptr_t             rd_ptr_q;
  skid_ptr_t             wr_ptr_q;
  logic [1:0]            occ_q;

  // Entry storage: written on push only.
  // NOTE: the storage array is deliberately not reset; occ_q gates every use, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      entry_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= skid_ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= skid_ptr_inc(rd_ptr_q);
      occ_q <= occ_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign head_o  = entry_q[rd_ptr_q];
  assign count_o = occ_q;

  a_no_overflow : assert property (@(posedge clk_i) disable iff (reset_i)
    !(push_i && !pop_i && occ_q == 2'(SKID_DEPTH)));

  a_no_underflow : assert property (@(posedge clk_i) disable iff (reset_i)
    !(pop_i && occ_q == 2'd0));

endmodule

// File: rtl/async_fifo_read_drain.sv
// Read-side consumer for async_fifo_system: pops the FIFO against its empty
// flag, buffers words in a skid buffer and presents a framed valid/ready stream.
module async_fifo_read_drain
  import async_fifo_read_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_read_req_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic [CNT_WIDTH-1:0]  word_cnt_o,
  output logic                  busy_o
);

  localparam int BEAT_WIDTH = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BURST_LEN - 1);

  rd_state_e             state_q;
  rd_state_e             state_d;
  logic                  inflight_q;
  logic [BEAT_WIDTH-1:0] beat_q;
  logic [CNT_WIDTH-1:0]  word_cnt_q;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic [2:0]            committed;
  logic                  holding;
  logic                  transfer;

  fifo_rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (inflight_q),
    .push_data_i(fifo_data_i),
    .pop_i      (transfer),
    .head_o     (head),
    .count_o    (occ)
  );

  // Buffered words plus the word in flight must fit the skid buffer.
  assign committed       = {1'b0, occ} + {2'b00, inflight_q};
  assign holding         = (occ != 2'd0) || inflight_q;
  assign fifo_read_req_o = (state_q == ST_RUN) && !fifo_empty_i && (committed < 3'(SKID_DEPTH));

  // Data is zeroed while invalid so the stream reads all-zero out of reset.
  assign m_valid_o  = (occ != 2'd0);
  assign m_data_o   = m_valid_o ? head : '0;
  assign m_last_o   = m_valid_o && (beat_q == LAST_BEAT);
  assign transfer   = m_valid_o && m_ready_i;
  assign word_cnt_o = word_cnt_q;
  assign busy_o     = (state_q != ST_IDLE);

  // Next-state logic: fetch in RUN, finish buffered work in DRAIN.
  // NOTE: state_d takes its default first so every path assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable_i) state_d = ST_RUN;
      ST_RUN:   if (!enable_i) state_d = holding ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (enable_i)      state_d = ST_RUN;
        else if (!holding) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, in-flight flag, burst beat and transfer counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_read_req_o;
      if (transfer) begin
        beat_q     <= (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_WIDTH'(1);
        word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_read_drain.sv
// Self-checking bench for async_fifo_read_drain with a behavioural FIFO model
// (1-cycle read latency). A second instance with a 4-bit counter shares stimulus.
module tb_async_fifo_read_drain;
  import async_fifo_read_drain_pkg::*;

  localparam int DW = 32;
  localparam int BL = 16;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          enable_i;
  logic          fifo_empty_i;
  logic [DW-1:0] fifo_data_i = '0;
  logic          fifo_read_req_o;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          m_ready_i;
  logic [15:0]   word_cnt_o;
  logic          busy_o;

  logic          req4, valid4, last4, busy4;
  logic [DW-1:0] data4;
  logic [3:0]    cnt4;

  always #5 clk_i = ~clk_i;

  async_fifo_read_drain #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_read_req_o(fifo_read_req_o), .m_valid_o(m_valid_o), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .m_ready_i(m_ready_i), .word_cnt_o(word_cnt_o), .busy_o(busy_o)
  );

  async_fifo_read_drain #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(4)) dut_w4 (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_read_req_o(req4), .m_valid_o(valid4), .m_data_o(data4),
    .m_last_o(last4), .m_ready_i(m_ready_i), .word_cnt_o(cnt4), .busy_o(busy4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: pops on request, data appears on the following cycle.
  logic [DW-1:0] fifo_mem [256];
  int   wr_idx    = 0;
  int   rd_idx    = 0;
  int   underflow = 0;
  logic flush     = 1'b0;

  assign fifo_empty_i = (rd_idx == wr_idx);

  always @(posedge clk_i) begin
    if (flush) begin
      rd_idx <= wr_idx;
    end else if (fifo_read_req_o) begin
      if (rd_idx == wr_idx) begin
        underflow <= underflow + 1;
      end else begin
        fifo_data_i <= fifo_mem[rd_idx[7:0]];
        rd_idx      <= rd_idx + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_mem[wr_idx[7:0]] = v;
    wr_idx++;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    flush   = 1'b1;
    repeat (2) step();
    reset_i = 1'b0;
    flush   = 1'b0;
  endtask

  typedef struct {
    logic          rst, en, rdy;
    logic          exp_req, exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_last, exp_busy;
    logic [15:0]   exp_cnt;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int got;
    int first;
    int found;
    logic any_req;

    // Reset with a non-empty FIFO, single-word empty edge, then drain to IDLE.
    //            rst   en    rdy   req   valid data       last  busy  cnt
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 16'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 16'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 16'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5,    1'b0, 1'b1, 16'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5,    1'b0, 1'b1, 16'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA5,    1'b0, 1'b1, 16'd0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 16'd1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 16'd1};

    reset_i   = 1'b1;
    enable_i  = 1'b1;
    m_ready_i = 1'b0;
    push(32'hA5);
    step();

    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      reset_i   = vecs[i].rst;
      enable_i  = vecs[i].en;
      m_ready_i = vecs[i].rdy;
      @(negedge clk_i);
      check($sformatf("vec%0d_req", i),   fifo_read_req_o, vecs[i].exp_req);
      check($sformatf("vec%0d_valid", i), m_valid_o,       vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), m_data_o, vecs[i].exp_data);
      check($sformatf("vec%0d_last", i),  m_last_o,        vecs[i].exp_last);
      check($sformatf("vec%0d_busy", i),  busy_o,          vecs[i].exp_busy);
      check($sformatf("vec%0d_cnt", i),   word_cnt_o,      vecs[i].exp_cnt);
    end
    check("empty_edge_pops", rd_idx, 1);
    check("empty_edge_underflow", underflow, 0);

    // Streaming 40 words at full rate.
    step();
    do_reset();
    enable_i  = 1'b1;
    m_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) push(DW'(i));
    got   = 0;
    first = -1;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) step();
      @(negedge clk_i);
      if (m_valid_o && m_ready_i) begin
        if (got == 0) first = k;
        else check($sformatf("stream_cycle%0d", got), k, first + got);
        check($sformatf("stream_data%0d", got), m_data_o, got);
        check($sformatf("stream_last%0d", got), m_last_o, (got % BL) == BL - 1);
        got++;
        if (got == 40) break;
      end
    end
    check("stream_count", got, 40);
    check("stream_start_latency", first, 3);
    step();
    @(negedge clk_i);
    check("stream_word_cnt", word_cnt_o, 40);
    check("stream_cnt4", cnt4, 40 % 16);
    check("stream_no_extra", m_valid_o, 1'b0);

    // Backpressure: ten stalled cycles, then release.
    step();
    do_reset();
    enable_i  = 1'b1;
    m_ready_i = 1'b0;
    base      = rd_idx;
    for (int i = 0; i < 20; i++) push(DW'(100 + i));
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      @(negedge clk_i);
      if (k >= 5) begin
        check($sformatf("bp_valid_c%0d", k), m_valid_o, 1'b1);
        check($sformatf("bp_hold_c%0d", k),  m_data_o,  100);
      end
    end
    check("bp_req_off", fifo_read_req_o, 1'b0);
    check("bp_buffered", rd_idx - base, 3);
    step();
    m_ready_i = 1'b1;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      @(negedge clk_i);
      if (m_valid_o && m_ready_i) begin
        check($sformatf("bp_data%0d", got), m_data_o, 100 + got);
        got++;
        if (got == 20) break;
      end
    end
    check("bp_count", got, 20);
    check("bp_popped", rd_idx - base, 20);
    step();
    @(negedge clk_i);
    check("bp_no_extra", m_valid_o, 1'b0);

    // Drain: enable drops with two words buffered and one in flight.
    step();
    do_reset();
    enable_i  = 1'b1;
    m_ready_i = 1'b0;
    base      = rd_idx;
    for (int i = 0; i < 10; i++) push(DW'(200 + i));
    repeat (4) step();
    enable_i = 1'b0;
    @(negedge clk_i);
    check("drain_req_full", fifo_read_req_o, 1'b0);
    check("drain_popped_pre", rd_idx - base, 3);
    step();
    m_ready_i = 1'b1;
    @(negedge clk_i);
    check("drain_state", 64'(dut.state_q), 64'(ST_DRAIN));
    check("drain_busy", busy_o, 1'b1);
    got     = 0;
    any_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        step();
        @(negedge clk_i);
      end
      if (fifo_read_req_o) any_req = 1'b1;
      if (!busy_o) break;
      if (m_valid_o && m_ready_i) begin
        check($sformatf("drain_data%0d", got), m_data_o, 200 + got);
        got++;
      end
    end
    check("drain_count", got, 3);
    check("drain_idle", busy_o, 1'b0);
    check("drain_no_req", any_req, 1'b0);
    check("drain_popped_post", rd_idx - base, 3);

    // Counter wrap on the 4-bit instance.
    step();
    do_reset();
    enable_i  = 1'b1;
    m_ready_i = 1'b1;
    for (int i = 0; i < 17; i++) push(DW'(400 + i));
    got = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      @(negedge clk_i);
      if (m_valid_o && m_ready_i) begin
        got++;
        if (got == 17) break;
      end
    end
    check("wrap_count", got, 17);
    step();
    @(negedge clk_i);
    check("wrap_cnt4", cnt4, 4'd1);
    check("wrap_cnt16", word_cnt_o, 17);

    // Reset mid-burst: the next m_last must land on the BL-th word after reset.
    step();
    for (int i = 0; i < 40; i++) push(DW'(500 + i));
    got = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      @(negedge clk_i);
      if (m_valid_o && m_ready_i) begin
        got++;
        if (got == 5) break;
      end
    end
    check("midrst_pre_count", got, 5);
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    @(negedge clk_i);
    check("midrst_cnt_cleared", word_cnt_o, 0);
    check("midrst_valid_cleared", m_valid_o, 1'b0);
    got   = 0;
    found = -1;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) begin
        step();
        @(negedge clk_i);
      end
      if (m_valid_o && m_ready_i) begin
        if (m_last_o) begin
          found = got;
          break;
        end
        got++;
      end
    end
    check("midrst_last_index", found, BL - 1);
    check("underflow_total", underflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
